// File: rtl/seven_segment_scanner_n.sv
// rtl/seven_segment_scanner_n.sv - N-digit multiplexed seven-segment scanner with PWM and frame snapshot
//
// Ports:
//   clk           system clock
//   resetn        asynchronous active-low reset, synchronous release
//   digits_in     nibble i = digit i (digit 0 rightmost)
//   dp_in         1 = decimal point of digit i lit
//   digit_en      0 = digit i forced dark
//   hex_mode      1 = decode A-F, 0 = BCD with codes 10-15 blank
//   blank_lz      1 = suppress leading zeros
//   brightness    on-time in 1/16 of a slot, 0 = dark
//   a_to_g        segments bit0=a..bit6=g, active-low
//   decimal_point active-low decimal point
//   anode         one-cold digit select, active-low
module seven_segment_scanner_n #(
    parameter int NUM_DIGITS  = 8,
    parameter int SLOT_CYCLES = 262144
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    hex_mode,
    input  logic                    blank_lz,
    input  logic [3:0]              brightness,
    output logic [6:0]              a_to_g,
    output logic                    decimal_point,
    output logic [NUM_DIGITS-1:0]   anode
);

    localparam int PW = $clog2(SLOT_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           prescaler;
    logic [IW-1:0]           scan_idx;
    logic                    first_cycle;
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_en;
    logic                    snap_hex;
    logic                    snap_blz;

    logic                    slot_end;
    logic                    frame_load;

    // Frame view actually decoded. In the very first cycle after reset the
    // snapshot is being loaded, so the live inputs are used directly; this
    // keeps slot 0 of the first frame full length.
    logic [4*NUM_DIGITS-1:0] cur_digits;
    logic [NUM_DIGITS-1:0]   cur_dp;
    logic [NUM_DIGITS-1:0]   cur_en;
    logic                    cur_hex;
    logic                    cur_blz;

    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              nibble;
    logic [3:0]              phase;
    logic                    show;
    logic                    seg_on;
    logic                    dp_on;
    logic [6:0]              seg_d;
    logic                    dp_d;
    logic [NUM_DIGITS-1:0]   anode_d;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    assign slot_end   = &prescaler;
    assign frame_load = first_cycle | (slot_end & (scan_idx == LAST_IDX));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prescaler   <= '0;
            scan_idx    <= '0;
            first_cycle <= 1'b1;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_en     <= '0;
            snap_hex    <= 1'b0;
            snap_blz    <= 1'b0;
        end else begin
            prescaler   <= prescaler + 1'b1;
            first_cycle <= 1'b0;
            if (slot_end) begin
                scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
            end
            if (frame_load) begin
                snap_digits <= digits_in;
                snap_dp     <= dp_in;
                snap_en     <= digit_en;
                snap_hex    <= hex_mode;
                snap_blz    <= blank_lz;
            end
        end
    end

    assign cur_digits = first_cycle ? digits_in : snap_digits;
    assign cur_dp     = first_cycle ? dp_in     : snap_dp;
    assign cur_en     = first_cycle ? digit_en  : snap_en;
    assign cur_hex    = first_cycle ? hex_mode  : snap_hex;
    assign cur_blz    = first_cycle ? blank_lz  : snap_blz;

    // Leading-zero run scanned from the leftmost digit down; digit 0 always shows.
    always_comb begin
        logic zero_run;
        lz_blank = '0;
        zero_run = cur_blz;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run & (cur_digits[4*i +: 4] == 4'h0) & ~cur_dp[i];
            lz_blank[i] = (i != 0) & zero_run;
        end
    end

    assign nibble = cur_digits[4*scan_idx +: 4];
    assign phase  = prescaler[PW-1 -: 4];

    // An invalid BCD code darkens the segments but a set decimal point still
    // needs its anode driven.
    always_comb begin
        show    = cur_en[scan_idx] & (phase < brightness) & ~lz_blank[scan_idx];
        seg_on  = show & (cur_hex | (nibble <= 4'd9));
        dp_on   = show & cur_dp[scan_idx];
        seg_d   = seg_on ? decode(nibble) : 7'h7F;
        dp_d    = ~dp_on;
        anode_d = '1;
        if (seg_on | dp_on) begin
            anode_d = ~(NUM_DIGITS'(1) << scan_idx);
        end
    end

    // Anode and cathodes share one register stage so they always change together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_to_g        <= 7'h7F;
            decimal_point <= 1'b1;
            anode         <= '1;
        end else begin
            a_to_g        <= seg_d;
            decimal_point <= dp_d;
            anode         <= anode_d;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner_n.sv
// tb/tb_seven_segment_scanner_n.sv - directed self-checking bench for seven_segment_scanner_n
module tb_seven_segment_scanner_n;

    logic        clk;
    logic        resetn;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        hex_mode;
    logic        blank_lz;
    logic [3:0]  brightness;
    logic [6:0]  a_to_g;
    logic        decimal_point;
    logic [3:0]  anode;

    int n_checks   = 0;
    int n_fail     = 0;
    int multi_low  = 0;
    int waited;

    seven_segment_scanner_n #(
        .NUM_DIGITS  (4),
        .SLOT_CYCLES (32)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .digits_in     (digits_in),
        .dp_in         (dp_in),
        .digit_en      (digit_en),
        .hex_mode      (hex_mode),
        .blank_lz      (blank_lz),
        .brightness    (brightness),
        .a_to_g        (a_to_g),
        .decimal_point (decimal_point),
        .anode         (anode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn && ($countones(~anode) > 1)) multi_low++;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic restart(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en,
                           input logic hx, input logic lz, input logic [3:0] br);
        @(negedge clk);
        resetn     = 1'b0;
        digits_in  = d;
        dp_in      = dp;
        digit_en   = en;
        hex_mode   = hx;
        blank_lz   = lz;
        brightness = br;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Wait for the digit's anode, check its cathodes, then measure how many
    // consecutive samples it stays selected.
    task automatic measure(input string tag, input logic [3:0] an, input logic [6:0] sg,
                           input logic dpx, input int len, output int w);
        int run;
        w   = 0;
        run = 0;
        while (anode !== an && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk_eq({tag, "_anode"}, 32'(anode), 32'(an));
        chk_eq({tag, "_seg"}, 32'(a_to_g), 32'(sg));
        chk_eq({tag, "_dp"}, 32'(decimal_point), 32'(dpx));
        while (anode === an && run < 100) begin
            run++;
            @(negedge clk);
        end
        chk_eq({tag, "_len"}, run, len);
    endtask

    task automatic count_low(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (anode !== 4'hF) n++;
        end
    endtask

    initial begin
        int n;
        resetn     = 1'b0;
        digits_in  = '0;
        dp_in      = '0;
        digit_en   = '0;
        hex_mode   = 1'b0;
        blank_lz   = 1'b0;
        brightness = '0;

        // 1: reset mid-scan, then restart at index 0
        restart(16'h1234, 4'h0, 4'hF, 1'b0, 1'b0, 4'hF);
        repeat (40) @(negedge clk);
        chk_eq("t1_midscan_anode", 32'(anode), 32'hD);
        resetn = 1'b0;
        @(negedge clk);
        chk_eq("t1_rst_anode", 32'(anode), 32'hF);
        chk_eq("t1_rst_seg", 32'(a_to_g), 32'h7F);
        chk_eq("t1_rst_dp", 32'(decimal_point), 32'h1);
        resetn = 1'b1;

        // 2: BCD 1234, full brightness: 30 lit of each 32-cycle slot
        measure("t2_d0", 4'hE, 7'h19, 1'b1, 30, waited);
        chk_eq("t1_first_latency", waited, 1);
        measure("t2_d1", 4'hD, 7'h30, 1'b1, 30, waited);
        measure("t2_d2", 4'hB, 7'h24, 1'b1, 30, waited);
        measure("t2_d3", 4'h7, 7'h79, 1'b1, 30, waited);

        // 3: hex decode, then same codes in BCD are all dark
        restart(16'hABCD, 4'h0, 4'hF, 1'b1, 1'b0, 4'hF);
        measure("t3_d0", 4'hE, 7'h21, 1'b1, 30, waited);
        measure("t3_d1", 4'hD, 7'h46, 1'b1, 30, waited);
        measure("t3_d2", 4'hB, 7'h03, 1'b1, 30, waited);
        measure("t3_d3", 4'h7, 7'h08, 1'b1, 30, waited);
        restart(16'hABCD, 4'h0, 4'hF, 1'b0, 1'b0, 4'hF);
        count_low(140, n);
        chk_eq("t3_bcd_dark", n, 0);

        // invalid BCD with dp set: anode driven for dp only
        restart(16'hABCD, 4'h1, 4'hF, 1'b0, 1'b0, 4'hF);
        measure("t3_dp_only", 4'hE, 7'h7F, 1'b0, 30, waited);

        // 4: leading-zero blanking
        restart(16'h0050, 4'h0, 4'hF, 1'b0, 1'b1, 4'hF);
        measure("t4_d0", 4'hE, 7'h40, 1'b1, 30, waited);
        measure("t4_d1", 4'hD, 7'h12, 1'b1, 30, waited);
        count_low(60, n);
        chk_eq("t4_lz_dark", n, 0);
        restart(16'h0050, 4'h4, 4'hF, 1'b0, 1'b1, 4'hF);
        measure("t4b_d0", 4'hE, 7'h40, 1'b1, 30, waited);
        measure("t4b_d1", 4'hD, 7'h12, 1'b1, 30, waited);
        measure("t4b_d2", 4'hB, 7'h40, 1'b0, 30, waited);
        count_low(28, n);
        chk_eq("t4b_d3_dark", n, 0);

        // 5: mid-frame change only visible from next frame
        restart(16'h1234, 4'h0, 4'hF, 1'b0, 1'b0, 4'hF);
        measure("t5_d0", 4'hE, 7'h19, 1'b1, 30, waited);
        digits_in = 16'h5678;
        measure("t5_d1_old", 4'hD, 7'h30, 1'b1, 30, waited);
        measure("t5_d2_old", 4'hB, 7'h24, 1'b1, 30, waited);
        measure("t5_d3_old", 4'h7, 7'h79, 1'b1, 30, waited);
        measure("t5_d0_new", 4'hE, 7'h00, 1'b1, 30, waited);
        measure("t5_d1_new", 4'hD, 7'h78, 1'b1, 30, waited);

        // per-digit enable
        restart(16'h1234, 4'h0, 4'b1101, 1'b0, 1'b0, 4'hF);
        measure("ten_d0", 4'hE, 7'h19, 1'b1, 30, waited);
        repeat (4) @(negedge clk);
        count_low(28, n);
        chk_eq("ten_d1_dark", n, 0);
        measure("ten_d2", 4'hB, 7'h24, 1'b1, 30, waited);

        // 6: brightness 0 dark for 4 frames; brightness 8 is half duty
        restart(16'h1234, 4'h0, 4'hF, 1'b0, 1'b0, 4'h0);
        count_low(512, n);
        chk_eq("t6_bright0_dark", n, 0);
        restart(16'h1234, 4'h0, 4'hF, 1'b0, 1'b0, 4'h8);
        measure("t6_d0", 4'hE, 7'h19, 1'b1, 16, waited);
        measure("t6_d1", 4'hD, 7'h30, 1'b1, 16, waited);
        measure("t6_d2", 4'hB, 7'h24, 1'b1, 16, waited);
        measure("t6_d3", 4'h7, 7'h79, 1'b1, 16, waited);

        chk_eq("one_cold", multi_low, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
